// File: rtl/ula_nibble_sequencer_pkg.sv
// rtl/ula_nibble_sequencer_pkg.sv - shared types and ALU select constants for the nibble sequencer
//
// Purpose : FSM state encoding, commonly used 74181 function selects and the
//           helper that tells which arithmetic selects report a borrow on
//           their carry output.
// Ports   : none (package).
package ula_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] ULA_ADD = 4'b1001;  // A plus B            (m=0)
  localparam logic [3:0] ULA_SUB = 4'b0110;  // A minus B minus 1   (m=0)
  localparam logic [3:0] ULA_XOR = 4'b0110;  // A xor B             (m=1)
  localparam logic [3:0] ULA_DEC = 4'b1111;  // A minus 1           (m=0)

  // For these arithmetic selects the ALU carry output means "borrow",
  // so the chain has to invert it before feeding the next nibble.
  function automatic logic is_borrow_class(input logic [3:0] sel);
    return (sel == 4'b0011) || (sel == 4'b0110) || (sel == 4'b0111) ||
           (sel == 4'b1011) || (sel == 4'b1111);
  endfunction

endpackage

// File: rtl/ula_nibble_sequencer_if.sv
// rtl/ula_nibble_sequencer_if.sv - bus between the sequencer and one 4-bit ALU slice
//
// Purpose : groups the per-nibble ALU request (operands, function, carry) and
//           the ALU response (F, carry out, A=B).
// Signals : alu_a/alu_b  4  operand nibbles          (master -> slave)
//           alu_s        4  function select          (master -> slave)
//           alu_m        1  1 = logic, 0 = arith     (master -> slave)
//           alu_c_in     1  carry into the nibble    (master -> slave)
//           alu_b_in     1  unused borrow input, 0   (master -> slave)
//           alu_f        4  nibble result            (slave -> master)
//           alu_c_out    1  nibble carry/borrow out  (slave -> master)
//           alu_a_eq_b   1  nibble equality          (slave -> master)
interface ula_nibble_sequencer_if;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_s;
  logic       alu_m;
  logic       alu_c_in;
  logic       alu_b_in;
  logic [3:0] alu_f;
  logic       alu_c_out;
  logic       alu_a_eq_b;

  modport master (
    output alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_b_in,
    input  alu_f, alu_c_out, alu_a_eq_b
  );

  modport slave (
    input  alu_a, alu_b, alu_s, alu_m, alu_c_in, alu_b_in,
    output alu_f, alu_c_out, alu_a_eq_b
  );
endinterface

// File: rtl/ula_nibble_sequencer.sv
// rtl/ula_nibble_sequencer.sv - runs a WIDTH-bit ALU operation nibble-serially on a 4-bit ALU
//
// Purpose : latches operands/function on an accepted start, issues one nibble
//           per cycle (LSB first) to the ALU, chains the carry between nibbles
//           and assembles result and flags. IDLE -> RUN (NIBBLES cycles) -> DONE.
// Ports   : i_clk, i_rst_n        clock, synchronous active-low reset
//           i_start / o_ready     request, accepted when both high (ready only in IDLE)
//           i_op_a, i_op_b        WIDTH-bit operands
//           i_sel, i_mode         ALU function select and logic/arith mode
//           i_carry_in            carry into nibble 0
//           o_result              assembled F, held until the next accepted op
//           o_carry_out           final chain carry (0 in logic mode)
//           o_a_eq_b              AND of all nibble A=B outputs
//           o_done                one-cycle pulse, outputs valid from this cycle
//           o_zero                result == 0 (only with ULA_SEQ_ZERO_FLAG_EN)
//           alu                   master side of ula_nibble_sequencer_if
// Options : ULA_SEQ_ZERO_FLAG_EN adds the o_zero flag.
module ula_nibble_sequencer
  import ula_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  output logic                          o_ready,
  input  logic [WIDTH-1:0]              i_op_a,
  input  logic [WIDTH-1:0]              i_op_b,
  input  logic [3:0]                    i_sel,
  input  logic                          i_mode,
  input  logic                          i_carry_in,
  output logic [WIDTH-1:0]              o_result,
  output logic                          o_carry_out,
  output logic                          o_a_eq_b,
  output logic                          o_done,
`ifdef ULA_SEQ_ZERO_FLAG_EN
  output logic                          o_zero,
`endif
  ula_nibble_sequencer_if.master        alu
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_sel;
  logic               r_mode;
  logic               r_chain;
  logic               r_eq;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry_out;
  logic               r_a_eq_b;
  logic               r_ready;
  logic               r_done;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic               r_zero;
`endif

  logic               w_last;
  logic               w_next_c;
  logic               w_eq_next;
  logic [WIDTH-1:0]   w_result_next;

  // Latched registers reset to zero, so the ALU bus is all-zero out of reset.
  assign alu.alu_a    = r_a[{r_idx, 2'b00} +: 4];
  assign alu.alu_b    = r_b[{r_idx, 2'b00} +: 4];
  assign alu.alu_s    = r_sel;
  assign alu.alu_m    = r_mode;
  assign alu.alu_c_in = r_chain;
  assign alu.alu_b_in = 1'b0;

  assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_eq_next = r_eq & alu.alu_a_eq_b;

  // Logic mode never propagates: chain keeps carry_in so every nibble sees it.
  assign w_next_c = r_mode ? r_chain :
                    (is_borrow_class(r_sel) ? ~alu.alu_c_out : alu.alu_c_out);

  // Result with the current nibble inserted; at the last nibble this is the
  // final value, which lets all flags be valid in the done cycle.
  always_comb begin
    w_result_next = r_result;
    w_result_next[{r_idx, 2'b00} +: 4] = alu.alu_f;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_mode      <= 1'b0;
      r_chain     <= 1'b0;
      r_eq        <= 1'b0;
      r_idx       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_a_eq_b    <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
      r_zero      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && r_ready) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_sel   <= i_sel;
            r_mode  <= i_mode;
            r_chain <= i_carry_in;
            r_eq    <= 1'b1;
            r_idx   <= '0;
            r_ready <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result <= w_result_next;
          r_eq     <= w_eq_next;
          r_chain  <= w_next_c;
          if (w_last) begin
            r_state     <= DONE;
            r_done      <= 1'b1;
            r_carry_out <= ~r_mode & w_next_c;
            r_a_eq_b    <= w_eq_next;
`ifdef ULA_SEQ_ZERO_FLAG_EN
            r_zero      <= (w_result_next == '0);
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_carry_out = r_carry_out;
  assign o_a_eq_b    = r_a_eq_b;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  assign o_zero      = r_zero;
`endif

endmodule

// File: tb/tb_ula_nibble_sequencer.sv
// tb/tb_ula_nibble_sequencer.sv - directed self-checking bench for ula_nibble_sequencer (WIDTH=16)
module tb_ula_nibble_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  sel;
  logic        mode;
  logic        cin;
  logic [15:0] result;
  logic        carry_out;
  logic        a_eq_b;
  logic        done;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic        zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ula_nibble_sequencer_if alu_bus ();

  ula_nibble_sequencer #(.WIDTH(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .o_ready     (ready),
    .i_op_a      (op_a),
    .i_op_b      (op_b),
    .i_sel       (sel),
    .i_mode      (mode),
    .i_carry_in  (cin),
    .o_result    (result),
    .o_carry_out (carry_out),
    .o_a_eq_b    (a_eq_b),
    .o_done      (done),
`ifdef ULA_SEQ_ZERO_FLAG_EN
    .o_zero      (zero),
`endif
    .alu         (alu_bus)
  );

  // 4-bit ALU slice with active-high carry. Arithmetic: F = X + Y + c_in;
  // for borrow-class selects the carry pin reports borrow (inverted carry).
  logic [3:0] m_x;
  logic [3:0] m_y;
  logic [4:0] m_sum;
  logic       m_borrow_sel;

  always_comb begin
    m_x = alu_bus.alu_a;
    m_y = 4'h0;
    case (alu_bus.alu_s)
      4'b1001: m_y = alu_bus.alu_b;
      4'b0110: m_y = ~alu_bus.alu_b;
      4'b0011: begin m_x = 4'h0; m_y = 4'hF; end
      4'b1111: m_y = 4'hF;
      default: m_y = 4'h0;
    endcase
    m_sum = {1'b0, m_x} + {1'b0, m_y} + {4'b0000, alu_bus.alu_c_in};
    m_borrow_sel = (alu_bus.alu_s == 4'b0011) || (alu_bus.alu_s == 4'b0110) ||
                   (alu_bus.alu_s == 4'b0111) || (alu_bus.alu_s == 4'b1011) ||
                   (alu_bus.alu_s == 4'b1111);
    if (alu_bus.alu_m) begin
      case (alu_bus.alu_s)
        4'b0110: alu_bus.alu_f = alu_bus.alu_a ^ alu_bus.alu_b;
        4'b1011: alu_bus.alu_f = alu_bus.alu_a & alu_bus.alu_b;
        4'b1110: alu_bus.alu_f = alu_bus.alu_a | alu_bus.alu_b;
        default: alu_bus.alu_f = ~alu_bus.alu_a;
      endcase
      alu_bus.alu_c_out = 1'b0;
    end else begin
      alu_bus.alu_f     = m_sum[3:0];
      alu_bus.alu_c_out = m_borrow_sel ? ~m_sum[4] : m_sum[4];
    end
    alu_bus.alu_a_eq_b = (alu_bus.alu_a == alu_bus.alu_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation end to end; poke pulses a second start in the 2nd RUN cycle.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic m, input logic c,
                        input logic [15:0] exp_res, input logic exp_c, input logic exp_eq,
                        input bit poke);
    int cyc;
    int extra;
    bit seen;
    tick();
    op_a = a; op_b = b; sel = s; mode = m; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    check_eq({tag, ".busy"}, {31'd0, ready}, 32'd0);
    while (!seen && cyc < 20) begin
      start = (poke && cyc == 2);
      if (done) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    check_eq({tag, ".lat"}, cyc, 32'd5);
    check_eq({tag, ".res"}, {16'd0, result}, {16'd0, exp_res});
    check_eq({tag, ".cout"}, {31'd0, carry_out}, {31'd0, exp_c});
    check_eq({tag, ".eq"}, {31'd0, a_eq_b}, {31'd0, exp_eq});
`ifdef ULA_SEQ_ZERO_FLAG_EN
    check_eq({tag, ".zero"}, {31'd0, zero}, {31'd0, (exp_res == 16'h0000)});
`endif
    tick();
    check_eq({tag, ".pulse"}, {30'd0, done, ready}, 32'd1);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (done) extra++;
      end
      check_eq({tag, ".one_done"}, extra, 32'd0);
    end
  endtask

  initial begin
    int extra;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; sel = '0; mode = 1'b0; cin = 1'b0;
    tick();
    tick();
    check_eq("rst.ready", {31'd0, ready}, 32'd1);
    check_eq("rst.flags", {29'd0, done, carry_out, a_eq_b}, 32'd0);
    check_eq("rst.result", {16'd0, result}, 32'd0);
    check_eq("rst.bus", {18'd0, alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_s,
                         alu_bus.alu_m, alu_bus.alu_c_in}, 32'd0);
    check_eq("rst.b_in", {31'd0, alu_bus.alu_b_in}, 32'd0);
    rst_n = 1'b1;

    run_op("add",     16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("sub",     16'h5000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'h4FFF, 1'b1, 1'b0, 1'b0);
    run_op("sub_brw", 16'h0000, 16'h0001, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op("xor",     16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    run_op("xor_eq",  16'hABCD, 16'hABCD, 4'b0110, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op("m1_c0",   16'h1111, 16'h1111, 4'b0011, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_op("m1_c1",   16'h1111, 16'h1111, 4'b0011, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_op("dec",     16'h1000, 16'h1000, 4'b1111, 1'b0, 1'b0, 16'h0FFF, 1'b1, 1'b1, 1'b0);

    // Abort an op with reset in its second RUN cycle.
    tick();
    op_a = 16'h1234; op_b = 16'h1111; sel = 4'b1001; mode = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort.ready", {31'd0, ready}, 32'd1);
    check_eq("abort.result", {16'd0, result}, 32'd0);
    check_eq("abort.flags", {29'd0, done, carry_out, a_eq_b}, 32'd0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) extra++;
    end
    check_eq("abort.no_done", extra, 32'd0);
    run_op("fresh",   16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
